// File: rtl/io_irq_ctl32.sv
// io_irq_ctl32: IRQ controller with per-line enable, edge/level mode, W1C pending and
// a vector register that acknowledges the reported edge line on read.
module io_irq_ctl32 #(
   parameter logic [15:0] CAddrBase = 16'h0000,
   parameter int          CIrqCnt   = 16
) (
   input  logic               AClkH,
   input  logic               AResetHN,
   input  logic               AClkHEn,
   input  logic [15:0]        AIoAddr,
   output logic [63:0]        AIoMiso,
   input  logic [63:0]        AIoMosi,
   input  logic [3:0]         AIoWrSize,
   input  logic [3:0]         AIoRdSize,
   output logic               AIoAddrAck,
   output logic               AIoAddrErr,
   input  logic [CIrqCnt-1:0] AIrqI,
   output logic [CIrqCnt-1:0] AIrqO,
   output logic               AIrq,
   output logic [4:0]         AIrqIdx
);
   logic [CIrqCnt-1:0] FEn, FMode, FPend, FSmp;
   logic [CIrqCnt-1:0] wrData, w1cMask, ackClr, nextPend;
   logic [31:0]        rdData;
   logic [3:0]         accSize;
   logic [1:0]         regSel;
   logic               inRange, aligned, isWr, isRd, wrVec, rdAck, wrAck, ackRd;
   logic               unusedMosi;

   assign inRange    = AIoAddr[15:4] == CAddrBase[15:4];
   assign regSel     = AIoAddr[3:2];
   assign aligned    = AIoAddr[1:0] == 2'b00;
   assign accSize    = AIoRdSize | AIoWrSize;
   assign isWr       = |AIoWrSize;
   assign isRd       = |AIoRdSize;
   assign wrVec      = isWr && regSel == 2'd3;
   assign AIoAddrErr = inRange && |accSize && (accSize != 4'b0100 || !aligned || wrVec);
   assign AIoAddrAck = inRange && accSize == 4'b0100 && aligned && !wrVec;
   assign rdAck      = AIoAddrAck && isRd;
   assign wrAck      = AIoAddrAck && isWr;
   assign wrData     = AIoMosi[CIrqCnt-1:0];
   assign unusedMosi = ^AIoMosi;

   assign rdData  = regSel == 2'd0 ? 32'(FEn)
                  : regSel == 2'd1 ? 32'(FMode)
                  : regSel == 2'd2 ? 32'(FPend)
                  : {AIrq, 26'b0, AIrqIdx};
   assign AIoMiso = rdAck ? {32'b0, rdData} : 64'b0;

   assign AIrqO = FPend & FEn;
   assign AIrq  = |AIrqO;

   // Descending scan so the lowest set index wins.
   always_comb begin
      AIrqIdx = 5'd0;
      for (int i = CIrqCnt - 1; i >= 0; i--)
         if (AIrqO[i]) AIrqIdx = 5'(i);
   end

   assign ackRd   = rdAck && regSel == 2'd3 && AIrq;
   assign w1cMask = (wrAck && regSel == 2'd2) ? wrData : '0;

   always_comb begin
      ackClr = '0;
      for (int i = 0; i < CIrqCnt; i++)
         ackClr[i] = ackRd && AIrqIdx == 5'(i);
   end

   // Edge lines: a new rising edge beats any clear in the same cycle; level lines track the input.
   assign nextPend = (FMode & ((AIrqI & ~FSmp) | (FPend & ~(w1cMask | ackClr)))) | (~FMode & AIrqI);

   always_ff @(posedge AClkH or negedge AResetHN) begin
      if (!AResetHN) begin
         FEn   <= '0;
         FMode <= '0;
         FPend <= '0;
         FSmp  <= '0;
      end else if (AClkHEn) begin
         FSmp  <= AIrqI;
         FPend <= nextPend;
         if (wrAck && regSel == 2'd0) FEn <= wrData;
         if (wrAck && regSel == 2'd1) FMode <= wrData;
      end
   end
endmodule

// File: doc/io_irq_ctl32.md
Name: io_irq_ctl32

Overview:
- Parametrised successor to the 16-line IRQ enable mask.
- Adds per-line edge/level mode, pending latches with write-1-to-clear, a lowest-index-first priority encoder, and a vector register that acknowledges on read.
- Sits on the 16-bit IO bus between peripheral IRQ sources and the core interrupt input.

Parameters:
- CAddrBase, 16'h0000, IO base address; must be 16-byte aligned.
- CIrqCnt, 16, number of IRQ lines, 1..32.

Ports:
- AClkH  in  1  clock; one clock domain.
- AResetHN  in  1  asynchronous active-low reset.
- AClkHEn  in  1  clock enable; no register updates when low.
- AIoAddr  in  16  IO address.
- AIoMiso  out  64  read data; all zero when no read is decoded.
- AIoMosi  in  64  write data.
- AIoWrSize  in  4  one-hot write size: bit0 byte, bit1 word, bit2 dword, bit3 qword; 0 = no write.
- AIoRdSize  in  4  one-hot read size, same encoding.
- AIoAddrAck  out  1  address and size are valid for this block.
- AIoAddrErr  out  1  address hits this block but the size is illegal.
- AIrqI  in  CIrqCnt  raw IRQ inputs, synchronous to AClkH.
- AIrqO  out  CIrqCnt  pending & enabled, per line.
- AIrq  out  1  OR of AIrqO.
- AIrqIdx  out  5  lowest set index of AIrqO; 0 when none is set.

Behaviour:
- Register map, byte offsets from CAddrBase, dword access only:
  - +0 IrqEn: R/W.
  - +4 IrqMode: R/W; 1 = edge, 0 = level.
  - +8 IrqPend: R; write-1-to-clear.
  - +C IrqVec: R only; bit31 = AIrq, bits4:0 = AIrqIdx, other bits 0.
- Only bits CIrqCnt-1..0 exist. Unused bits read 0 and are ignored on write.
- Decode:
  - AIoAddrAck = address in base..base+F, dword-aligned, and the size is dword.
  - AIoAddrErr = address in range with any other nonzero size, or misaligned, or a write to +C.
  - Erroneous accesses have no effect and Miso = 0.
- Read data is combinational from registers in the same cycle as the address. AIoMiso[63:32] is always 0.
- State: FEn, FMode, FPend, FSmp (previous AIrqI sample). All reset to 0 asynchronously. Reset mid-operation drops all pending IRQs.
- Outputs are combinational from state only:
  - AIrqO = FPend & FEn.
  - AIrq and AIrqIdx are derived from AIrqO.
  - All outputs are 0 in reset.
- Per-line update, only when AClkHEn = 1:
  - Edge mode:
    - FPend set when AIrqI & ~FSmp.
    - FPend cleared by a W1C write to +8, or by an ack-read of +C that reports this line.
    - Set has priority over clear in the same cycle.
  - Level mode:
    - FPend <= AIrqI.
    - W1C and ack-read have no effect.
  - FSmp <= AIrqI every enabled cycle.
- Latency:
  - Input edge in cycle n → AIrqO/AIrq/AIrqIdx valid in cycle n+1.
  - IrqEn/IrqMode write in cycle n takes effect on AIrqO in cycle n+1.
- Ack-read:
  - An acked dword read of +C with AIrq = 1 clears FPend[AIrqIdx] at the clock edge, provided that line is in edge mode.
  - The read returns the pre-clear value.
  - Reading when AIrq = 0 has no side effect.
- Disabled lines still latch pending. Enabling such a line later asserts AIrqO immediately on the next cycle.
- Mode change edge→level: FPend follows the input from the next cycle.
- Mode change level→edge: the current FPend is retained until cleared.
- AClkHEn = 0: reads are still served. Writes and ack side-effects are dropped.

Test Plan:
- Reset → read +0/+4/+8 = 0, +C = 0x0; AIrq = 0, AIrqO = 0.
- Write +0 = 0x0000_0005, +4 = 0x5; pulse AIrqI[2] for 1 cycle → AIrqO = 0x4 next cycle, AIrqIdx = 2; write +8 = 0x4 → AIrqO = 0 next cycle.
- Edges on lines 2 and 0 in the same cycle, both enabled, edge mode → +C reads 0x8000_0000. The next +C read returns 0x8000_0002. The next returns 0x0000_0000.
- Level line 1, enabled: hold AIrqI[1] = 1 → AIrqO[1] stays 1 across a W1C write of 0x2; deassert the input → AIrqO[1] = 0 one cycle later.
- Edge on line 3 in the same cycle as a W1C of bit 3 → FPend[3] remains 1.
- Byte read at +0 → AIoAddrErr = 1, Miso = 0.
- Write to +C → AIoAddrErr = 1, no state change.
- Access at base+0x10 → Ack = 0, Err = 0.
- AClkHEn = 0 during an edge on line 0 → no pending is set.
- Assert AResetHN low with lines pending → all outputs 0 immediately.
